// File: rtl/fp16_accum_if.sv
// fp16_accum_if: operand strobe, clear and accumulator result bundle between converter, accumulator and host
interface fp16_accum_if;
    logic        clear;
    logic [15:0] dataIn;
    logic        R_I;
    logic [15:0] dataOut;
    logic        R_O;
    logic        busy;
    logic        error;
    modport master (output clear, dataIn, R_I, input dataOut, R_O, busy, error);
    modport slave  (input clear, dataIn, R_I, output dataOut, R_O, busy, error);
endinterface

// File: rtl/fp16_accum.sv
// fp16_accum: running binary16 accumulator, one operand per six-state unpack/align/add/normalise/round pass
module fp16_accum (
    input logic         clk,
    input logic         reset,
    fp16_accum_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;
    state_t state, state_nx;
    logic        ri_d, accept, r_o, err;
    logic [15:0] op, acc;
    logic        skip, rej, sa, sb;
    logic [4:0]  ea, eb;
    logic [13:0] ma, mb;
    logic        sx, sy;
    logic [4:0]  ex;
    logic [13:0] mx, my;
    logic        rs;
    logic [4:0]  re;
    logic [14:0] rm;
    logic        ns, nz;
    logic [5:0]  ne;
    logic [13:0] nm;
    logic        u_rej, u_skip;
    logic        a_swap;
    logic [4:0]  a_d, a_ds;
    logic [13:0] a_small, a_sh;
    logic [27:0] a_ext;
    logic        d_ge, d_s;
    logic [14:0] d_m;
    logic [3:0]  lz;
    logic        n_z;
    logic [5:0]  n_e;
    logic [13:0] n_m;
    logic        r_inc, r_ovf;
    logic [11:0] r_mant;
    logic [5:0]  r_e;
    logic [15:0] r_res;

    assign accept = state == IDLE && bus.R_I && !ri_d && !bus.clear;
    assign bus.dataOut = acc;
    assign bus.R_O = r_o;
    assign bus.busy = state != IDLE;
    assign bus.error = err;

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // fixed walk through the stages; clear aborts from anywhere
    always_comb begin
        state_nx = state;
        state_nx = bus.clear ? IDLE :
                   state == IDLE ? (accept ? UNPACK : IDLE) :
                   state == ROUND ? IDLE : state_t'(state + 3'd1);
    end

    // unpack: Inf/NaN operand rejected, Inf accumulator stays put, exp 0 flushes to zero
    always_comb begin
        u_rej = op[14:10] == 5'h1f;
        u_skip = u_rej || acc[14:10] == 5'h1f;
    end

    // align: barrel-shift the smaller-exponent mantissa, collapsing lost bits into sticky
    always_comb begin
        a_swap = eb > ea;
        a_d = a_swap ? eb - ea : ea - eb;
        a_ds = a_d > 5'd14 ? 5'd14 : a_d;
        a_small = a_swap ? ma : mb;
        a_ext = {a_small, 14'b0} >> a_ds;
        a_sh = a_ext[27:14] | {13'b0, |a_ext[13:0]};
    end

    // add/subtract magnitudes; exact zero is forced positive
    always_comb begin
        d_ge = mx >= my;
        d_m = sx == sy ? {1'b0, mx} + {1'b0, my} : d_ge ? {1'b0, mx - my} : {1'b0, my - mx};
        d_s = d_m == 15'd0 ? 1'b0 : sx == sy ? sx : d_ge ? sx : sy;
    end

    // leading-zero count of the non-carry result
    always_comb begin
        lz = 4'd14;
        for (int i = 0; i < 14; i++) if (rm[i]) lz = 4'(13 - i);
    end

    // normalise: carry shifts right keeping sticky, otherwise shift left; underflow becomes +0
    always_comb begin
        n_m = rm[14] ? {rm[14:2], rm[1] | rm[0]} : rm[13:0] << lz;
        n_e = rm[14] ? {1'b0, re} + 6'd1 : {1'b0, re} - {2'b0, lz};
        n_z = !rm[14] && (rm[13:0] == 14'd0 || {1'b0, re} <= {2'b0, lz});
    end

    // round to nearest even on guard and round|sticky, saturating to signed Inf
    always_comb begin
        r_inc = nm[2] & (nm[3] | nm[1] | nm[0]);
        r_mant = {1'b0, nm[13:3]} + {11'b0, r_inc};
        r_e = ne + {5'b0, r_mant[11]};
        r_ovf = !nz && r_e >= 6'd31;
        r_res = nz ? 16'h0000 : r_ovf ? {ns, 5'h1f, 10'h0} : {ns, r_e[4:0], r_mant[9:0]};
    end

    // stage registers reload every cycle from stable upstream values, so each stage sees its operand
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            {skip, rej, sa, sb, ea, eb, ma, mb} <= '0;
            {sx, sy, ex, mx, my} <= '0;
            {rs, re, rm} <= '0;
            {ns, nz, ne, nm} <= '0;
        end else begin
            skip <= u_skip;
            rej <= u_rej;
            sa <= acc[15];
            ea <= acc[14:10];
            ma <= acc[14:10] == 5'd0 ? 14'd0 : {1'b1, acc[9:0], 3'b0};
            sb <= op[15];
            eb <= op[14:10];
            mb <= op[14:10] == 5'd0 ? 14'd0 : {1'b1, op[9:0], 3'b0};
            sx <= a_swap ? sb : sa;
            sy <= a_swap ? sa : sb;
            ex <= a_swap ? eb : ea;
            mx <= a_swap ? mb : ma;
            my <= a_sh;
            rs <= d_s;
            re <= ex;
            rm <= d_m;
            ns <= rs;
            nz <= n_z;
            ne <= n_e;
            nm <= n_m;
        end

    // operand capture, accumulator commit, sticky error and result pulse
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ri_d <= 1'b0;
            op <= 16'h0;
            acc <= 16'h0;
            err <= 1'b0;
            r_o <= 1'b0;
        end else begin
            ri_d <= bus.R_I;
            r_o <= 1'b0;
            if (accept) op <= bus.dataIn;
            if (bus.clear) begin
                acc <= 16'h0;
                err <= 1'b0;
            end else if (state == ROUND) begin
                r_o <= 1'b1;
                if (!skip) acc <= r_res;
                err <= err | rej | (!skip & r_ovf);
            end
        end
endmodule

// File: tb/tb_fp16_accum.sv
// tb_fp16_accum: directed vectors against hand-computed fp16 sums, handshake and abort behaviour
module tb_fp16_accum;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    fp16_accum_if bus();
    fp16_accum dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // pulse R_I for one cycle from a negedge and wait (bounded) for R_O; lat=99 on timeout
    task automatic send(input logic [15:0] v, output int lat);
        bus.dataIn = v;
        bus.R_I = 1'b1;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.R_I = 1'b0;
            if (bus.R_O) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic clear_acc();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_ro(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.R_O) cnt++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.dataOut !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus.dataOut); end
        checks++; if (bus.R_O !== 1'b0) begin errors++; $display("FAIL reset_ro got %b want 0", bus.R_O); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat;
        send(16'h3C00, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL add1_latency got %0d want 6", lat); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add1_busy_at_ro got %b want 0", bus.busy); end
        send(16'h4000, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL add2_latency got %0d want 6", lat); end
        checks++; if (bus.dataOut !== 16'h4200) begin errors++; $display("FAIL add_sum got %h want 4200", bus.dataOut); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL add_error got %b want 0", bus.error); end
    endtask

    task automatic test_cancel_zero();
        int lat;
        clear_acc();
        checks++; if (bus.dataOut !== 16'h0000) begin errors++; $display("FAIL clear_idle got %h want 0000", bus.dataOut); end
        send(16'h3C00, lat);
        send(16'hBC00, lat);
        checks++; if (bus.dataOut !== 16'h0000) begin errors++; $display("FAIL cancel got %h want 0000", bus.dataOut); end
        send(16'h8000, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL negzero_latency got %0d want 6", lat); end
        send(16'h0001, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL subnormal_latency got %0d want 6", lat); end
        checks++; if (bus.dataOut !== 16'h0000) begin errors++; $display("FAIL zero_flush got %h want 0000", bus.dataOut); end
        send(16'hBC00, lat);
        send(16'h3800, lat);
        checks++; if (bus.dataOut !== 16'hB800) begin errors++; $display("FAIL neg_sum got %h want b800", bus.dataOut); end
    endtask

    task automatic test_rounding();
        int lat;
        clear_acc();
        send(16'h6800, lat);
        send(16'h3C00, lat);
        checks++; if (bus.dataOut !== 16'h6800) begin errors++; $display("FAIL tie_even got %h want 6800", bus.dataOut); end
        send(16'h4000, lat);
        checks++; if (bus.dataOut !== 16'h6801) begin errors++; $display("FAIL round_exact got %h want 6801", bus.dataOut); end
    endtask

    task automatic test_overflow_clear();
        int lat;
        clear_acc();
        send(16'h7BFF, lat);
        send(16'h7BFF, lat);
        checks++; if (bus.dataOut !== 16'h7C00) begin errors++; $display("FAIL overflow got %h want 7c00", bus.dataOut); end
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL overflow_error got %b want 1", bus.error); end
        send(16'h3C00, lat);
        checks++; if (bus.dataOut !== 16'h7C00) begin errors++; $display("FAIL inf_sticky got %h want 7c00", bus.dataOut); end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checks++; if (bus.dataOut !== 16'h0000) begin errors++; $display("FAIL clear_data got %h want 0000", bus.dataOut); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL clear_error got %b want 0", bus.error); end
    endtask

    task automatic test_reject();
        int lat;
        clear_acc();
        send(16'h3C00, lat);
        send(16'h4000, lat);
        send(16'h7E00, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL nan_latency got %0d want 6", lat); end
        checks++; if (bus.dataOut !== 16'h4200) begin errors++; $display("FAIL nan_keep got %h want 4200", bus.dataOut); end
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL nan_error got %b want 1", bus.error); end
    endtask

    task automatic test_hold();
        int c1, c2;
        clear_acc();
        bus.dataIn = 16'h3C00;
        bus.R_I = 1'b1;
        count_ro(20, c1);
        bus.R_I = 1'b0;
        count_ro(8, c2);
        checks++; if (c1 + c2 !== 1) begin errors++; $display("FAIL hold_once got %0d want 1", c1 + c2); end
        checks++; if (bus.dataOut !== 16'h3C00) begin errors++; $display("FAIL hold_value got %h want 3c00", bus.dataOut); end
    endtask

    task automatic test_busy_ignore();
        int c;
        clear_acc();
        bus.dataIn = 16'h3C00;
        bus.R_I = 1'b1;
        @(negedge clk);
        bus.R_I = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_high got %b want 1", bus.busy); end
        @(negedge clk);
        bus.dataIn = 16'h4000;
        bus.R_I = 1'b1;
        @(negedge clk);
        bus.R_I = 1'b0;
        count_ro(12, c);
        checks++; if (c !== 1) begin errors++; $display("FAIL busy_drop_count got %0d want 1", c); end
        checks++; if (bus.dataOut !== 16'h3C00) begin errors++; $display("FAIL busy_drop_value got %h want 3c00", bus.dataOut); end
    endtask

    task automatic test_reset_mid();
        int lat, c;
        clear_acc();
        send(16'h3C00, lat);
        send(16'h7E00, lat);
        bus.dataIn = 16'h4000;
        bus.R_I = 1'b1;
        @(negedge clk);
        bus.R_I = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.dataOut !== 16'h0000) begin errors++; $display("FAIL rst_mid_data got %h want 0000", bus.dataOut); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL rst_mid_error got %b want 0", bus.error); end
        checks++; if (bus.R_O !== 1'b0) begin errors++; $display("FAIL rst_mid_ro got %b want 0", bus.R_O); end
        @(negedge clk);
        reset = 1'b0;
        count_ro(10, c);
        checks++; if (c !== 0) begin errors++; $display("FAIL rst_mid_no_ro got %0d want 0", c); end
    endtask

    task automatic test_clear_mid();
        int lat, c;
        send(16'h3C00, lat);
        checks++; if (bus.dataOut !== 16'h3C00) begin errors++; $display("FAIL post_reset_add got %h want 3c00", bus.dataOut); end
        bus.dataIn = 16'h4000;
        bus.R_I = 1'b1;
        @(negedge clk);
        bus.R_I = 1'b0;
        repeat (3) @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_mid_busy got %b want 0", bus.busy); end
        count_ro(10, c);
        checks++; if (c !== 0) begin errors++; $display("FAIL clr_mid_no_ro got %0d want 0", c); end
        checks++; if (bus.dataOut !== 16'h0000) begin errors++; $display("FAIL clr_mid_data got %h want 0000", bus.dataOut); end
    endtask

    initial begin
        bus.clear = 1'b0;
        bus.R_I = 1'b0;
        bus.dataIn = 16'h0;
        test_reset();
        test_add();
        test_cancel_zero();
        test_rounding();
        test_overflow_clear();
        test_reject();
        test_hold();
        test_busy_ignore();
        test_reset_mid();
        test_clear_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp16_accum.md
# fp16_accum

Downstream consumer of the integer-to-half-precision converter: accepts IEEE 754 binary16 words over the R_I strobe and adds each one into a running fp16 accumulator. Each update passes through a fixed 6-state pipeline-in-time FSM (unpack, align, add, normalise, round). The block presents the updated sum with a one-cycle R_O pulse. It is the first arithmetic stage after conversion, and its dataOut feeds display and host readback.

## Interface
- No parameters; format fixed to binary16 (1 sign, 5 exponent bias 15, 10 fraction).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- clear  input  1  synchronous; zeroes accumulator and error.
- dataIn  input  16  fp16 operand; connects to the converter's dataOut.
- R_I  input  1  operand-valid strobe; connects to the converter's R_O.
- dataOut  output  16  current accumulator value, fp16.
- R_O  output  1  one-cycle pulse: accumulator updated or operand rejected.
- busy  output  1  high whenever the FSM is not in IDLE.
- error  output  1  sticky: overflow or NaN/Inf operand seen.

## Operation
- Reset values: dataOut 0x0000, R_O 0, busy 0, error 0, state IDLE, R_I delay flop 0.
- Acceptance: operand captured only in IDLE, on a rising edge of R_I (R_I=1 and previous-cycle R_I=0). A held-high R_I is accepted once. R_I edges while busy are dropped, not queued.
- clear priority:
  - clear beats R_I in IDLE.
  - While busy, clear aborts the operation: accumulator 0, error 0, state IDLE, no R_O pulse.
- FSM states: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> IDLE. Each state lasts exactly one cycle. No other branches except the abort path.
- UNPACK:
  - exp=0 (zero or subnormal) is flushed to zero, either sign.
  - exp=31 (Inf/NaN) is rejected: accumulator unchanged, error set, R_O still pulses at the normal time.
  - Normal operands get mantissa {1,frac} (11 bits), extended to 14 bits with guard, round and sticky zeros.
- ALIGN:
  - The operand with the smaller exponent is shifted right by d=|ea-eb| using a single-cycle barrel shift.
  - Bits shifted out are ORed into sticky.
  - If d>=14, the smaller operand becomes sticky-only.
- ADD:
  - Same signs: add magnitudes into a 15-bit result.
  - Different signs: subtract the smaller magnitude from the larger; the result takes the larger operand's sign.
  - Exact zero result is +0 (0x0000).
- NORM:
  - On carry-out, shift right 1 (sticky preserved) and increment exponent.
  - Otherwise, left-shift by leading-zero count in one cycle and decrement exponent.
  - If the exponent would drop below 1, the result is +0 (no subnormals produced).
- ROUND:
  - Round to nearest, ties to even, on guard / (round|sticky).
  - Mantissa overflow from rounding increments the exponent.
  - Exponent >=31 saturates to signed Inf (0x7C00/0xFC00) and sets error.
- Saturated Inf accumulator: subsequent finite adds keep Inf; adding opposite-sign Inf is impossible because Inf operands are rejected.
- error clears only by clear or reset.

## Timing
- Capture edge E0 (IDLE, R_I rising): dataIn registered, busy=1 from the cycle after E0.
- dataOut and R_O=1 update at edge E5; R_O is high for exactly the cycle after E5.
- busy=0 in the same cycle R_O=1; a new R_I rising edge in that cycle is accepted. Maximum throughput is one operand per 6 cycles.
- reset asserted mid-operation forces all outputs to reset values immediately, without waiting for clk. The operation in flight is lost.
- Simultaneous clear and R_I rising in IDLE: clear wins and the operand is dropped.

## Test plan
- Reset; send 0x3C00 (1.0) then 0x4000 (2.0) -> R_O pulses 6 cycles after each capture; final dataOut=0x4200 (3.0), error=0.
- From 0, send 0x3C00 then 0xBC00 (-1.0) -> dataOut=0x0000 (+0). Then send 0x8000 (-0) and 0x0001 (subnormal) -> dataOut stays 0x0000, R_O pulses for each.
- Rounding check:
  - From 0, send 0x6800 (2048) then 0x3C00 (1.0): tie rounds to even, dataOut=0x6800.
  - Then send 0x4000 (2.0): dataOut=0x6801 (2050).
- Overflow and clear:
  - Send 0x7BFF twice -> dataOut=0x7C00, error=1.
  - Pulse clear -> dataOut=0x0000, error=0 next cycle.
- Rejected operand: with accumulator 0x4200, send 0x7E00 (NaN) -> dataOut stays 0x4200, error=1, R_O pulses at E5.
- Handshake and reset:
  - Hold R_I high 20 cycles -> exactly one update.
  - Pulse R_I during busy -> ignored.
  - Assert reset at ALIGN -> dataOut/R_O/busy/error=0 before the next clk edge, no R_O afterwards.
  - Assert clear at NORM -> no R_O, dataOut=0x0000.
